// File: rtl/polyunit_seq.sv
// polyunit_seq: sequencer and write-back controller for the polynomial
// butterfly unit. It walks the NTT RAM for load, NTT, INTT and bypass passes,
// issues a read strobe every STEPS cycles, and writes the butterfly result
// back PIPEDEPTH cycles after each strobe.
// Optional build macro POLYUNIT_SEQ_CYCLECNT_EN adds op_cycles, the busy
// cycle count of the last completed operation.
module polyunit_seq #(
    parameter int WID       = 12,
    parameter int LANES     = 4,
    parameter int ADDWID    = 5,
    parameter int STEPS     = 8,
    parameter int PIPEDEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    run,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WID*LANES-1:0]    data_in,
    input  logic [WID*LANES-1:0]    bf_out,
    output logic [ADDWID-1:0]       rom_addr,
    output logic [ADDWID-1:0]       ram_ra,
    output logic                    ram_re,
    output logic [ADDWID-1:0]       ram_wa,
    output logic                    ram_we,
    output logic [WID*LANES-1:0]    ram_wdi,
    output logic [1:0]              but_sel
`ifdef POLYUNIT_SEQ_CYCLECNT_EN
    ,
    output logic [31:0]             op_cycles
`endif
);

    localparam int DW = WID * LANES;
    // Step counter needs at least one bit even when STEPS is 1.
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [ADDWID:0] LAST_WORD = (ADDWID + 1)'((1 << ADDWID) - 1);
    localparam logic [SW-1:0]   LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ADDWID:0]   rcnt_reg;
    logic [ADDWID:0]   wcnt_reg;
    logic [SW-1:0]     step_reg;
    logic [1:0]        sel_reg;
    logic              done_reg;
    logic              pipe_reg [PIPEDEPTH];

    logic              load_accept;
    logic              read_strobe;
    logic              wb_write;
    logic              last_word;

    assign load_accept = (state_reg == S_LOAD) && in_valid;
    assign read_strobe = (state_reg == S_READ) && (step_reg == '0);
    // The pipe is empty outside READ/DRAIN; the state gate is belt and braces.
    assign wb_write    = ((state_reg == S_READ) || (state_reg == S_DRAIN)) &&
                         pipe_reg[PIPEDEPTH-1];
    assign last_word   = (wcnt_reg == LAST_WORD);

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign in_ready = (state_reg == S_LOAD);
    assign ram_re   = read_strobe;
    assign ram_ra   = rcnt_reg[ADDWID-1:0];
    assign rom_addr = rcnt_reg[ADDWID-1:0];
    assign ram_we   = load_accept | wb_write;
    assign ram_wa   = wcnt_reg[ADDWID-1:0];
    assign ram_wdi  = load_accept ? data_in : (wb_write ? bf_out : DW'(0));
    assign but_sel  = sel_reg;

    // First stage of the read-to-write delay line captures the read strobe.
    always_ff @(posedge clk) begin
        if (rst) pipe_reg[0] <= 1'b0;
        else     pipe_reg[0] <= read_strobe;
    end

    generate
        for (genvar gi = 1; gi < PIPEDEPTH; gi++) begin : g_pipe
            // Remaining stages shift the strobe towards the write tap.
            always_ff @(posedge clk) begin
                if (rst) pipe_reg[gi] <= 1'b0;
                else     pipe_reg[gi] <= pipe_reg[gi-1];
            end
        end
    endgenerate

    // Main FSM: mode latch, address/step counters, write-back count, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            rcnt_reg  <= '0;
            wcnt_reg  <= '0;
            step_reg  <= '0;
            sel_reg   <= 2'd2;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        rcnt_reg <= '0;
                        wcnt_reg <= '0;
                        step_reg <= '0;
                        case (mode)
                            2'd0: begin state_reg <= S_LOAD; sel_reg <= 2'd2; end
                            2'd1: begin state_reg <= S_READ; sel_reg <= 2'd0; end
                            2'd2: begin state_reg <= S_READ; sel_reg <= 2'd1; end
                            default: begin state_reg <= S_READ; sel_reg <= 2'd2; end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                        if (last_word) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (step_reg == LAST_STEP) begin
                        step_reg <= '0;
                        rcnt_reg <= rcnt_reg + 1'b1;
                        if (rcnt_reg == LAST_WORD) state_reg <= S_DRAIN;
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                default: ; // DRAIN: only write-back activity below
            endcase
            // Write-back completion overrides the READ/DRAIN progression so a
            // long STEPS window can still finish inside READ.
            if (wb_write) begin
                wcnt_reg <= wcnt_reg + 1'b1;
                if (last_word) begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b1;
                    sel_reg   <= 2'd2;
                end
            end
        end
    end

`ifdef POLYUNIT_SEQ_CYCLECNT_EN
    logic [31:0] cyc_reg;
    logic [31:0] op_cycles_reg;
    logic        op_finish;

    assign op_finish = (load_accept | wb_write) && last_word;
    assign op_cycles = op_cycles_reg;

    // Busy-cycle counter; the total is published together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_reg       <= '0;
            op_cycles_reg <= '0;
        end else if (busy) begin
            if (op_finish) begin
                op_cycles_reg <= cyc_reg + 32'd1;
                cyc_reg       <= '0;
            end else begin
                cyc_reg <= cyc_reg + 32'd1;
            end
        end else begin
            cyc_reg <= '0;
        end
    end
`endif

endmodule

// File: doc/polyunit_seq.md
Name: polyunit_seq

Overview:
- Parametrised sequencer and write-back controller for the polynomial butterfly unit. Successor to the fixed 4-lane, 32-word, 8-step core.
- Drives ROM twiddle address, NTT RAM read/write addresses and enables, butterfly mode select, and the load/write-data mux.
- Sits between the top-level command interface (mode/run/done) and the butterfly array plus RAM.
- Adds explicit busy/done handshake, a pipeline-delayed write strobe with drain, and load backpressure. The fixed core lacked all three.

Parameters:
- WID, 12, coefficient width.
- LANES, 4, coefficients per RAM word; RAM word width is WID*LANES.
- ADDWID, 5, RAM/ROM address width; DEPTH = 2**ADDWID words.
- STEPS, 8, cycles spent per read address (at least 1).
- PIPEDEPTH, 16, cycles from a read strobe to its matching write strobe (at least 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mode  in  2  0=DATAIN, 1=NTT, 2=INTT, 3=BYPASS; sampled with run
- run  in  1  start request; level, sampled only in IDLE
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when the operation completes
- in_valid  in  1  load data valid (DATAIN mode)
- in_ready  out  1  load data accepted when in_valid & in_ready
- data_in  in  WID*LANES  load word
- bf_out  in  WID*LANES  butterfly array result word
- rom_addr  out  ADDWID  twiddle ROM address
- ram_ra  out  ADDWID  RAM read address
- ram_re  out  1  RAM read strobe
- ram_wa  out  ADDWID  RAM write address
- ram_we  out  1  RAM write enable
- ram_wdi  out  WID*LANES  RAM write data
- but_sel  out  2  butterfly mode: 0=NTT, 1=INTT, 2=BYPASS; held at 2 in IDLE/LOAD

Behaviour:
- Reset is synchronous to clk and active-high. All counters and addresses go to 0; state goes to IDLE.
- Outputs after reset: busy=0, done=0, in_ready=0, ram_re=0, ram_we=0, but_sel=2, ram_wdi=0.
- States: IDLE, LOAD, READ, DRAIN.
- IDLE:
  - on run=1, latch mode.
  - mode 0 goes to LOAD; modes 1/2/3 go to READ.
  - but_sel is latched here: 1 gives 0, 2 gives 1, 3 gives 2.
- LOAD:
  - in_ready=1.
  - Each accepted word: ram_we=1 combinationally, ram_wdi=data_in, ram_wa=write count.
  - Write count increments after each accept.
  - After the DEPTH-th accept, go to IDLE and pulse done on the next cycle.
  - in_valid=0 stalls with no write.
- READ:
  - Step counter starts at 0 on entry and wraps at STEPS-1.
  - ram_re=1 when step==0.
  - ram_ra and rom_addr equal the read count; read count increments when step==STEPS-1.
  - After the DEPTH-th strobe completes its step window, go to DRAIN.
- Write-back:
  - A PIPEDEPTH-long shift register carries ram_re.
  - Its tap drives ram_we with ram_wdi=bf_out and ram_wa=write count; write count increments per write.
  - This runs in both READ and DRAIN.
- DRAIN: no read strobes. When write count reaches DEPTH (the last write issued), go to IDLE; done pulses the cycle after the last ram_we.
- Counter widths are ADDWID+1 so that DEPTH is representable; ram addresses use the low ADDWID bits.
- run while busy is ignored. Mode changes while busy are ignored because mode is latched.
- run held high at done: a new operation starts on the first IDLE cycle, which is the cycle done is high.
- rst asserted mid-operation aborts immediately: no done pulse, and the shift register is cleared so no stray ram_we follows.
- STEPS < PIPEDEPTH is legal (writes overlap reads). STEPS=1 gives back-to-back strobes.

Optional Feature:
- Macro POLYUNIT_SEQ_CYCLECNT_EN.
- When defined, adds output op_cycles (32 bits): the count of busy cycles of the last completed operation.
  - Updated on the done pulse.
  - Reset to 0; not updated on abort.
- When undefined, the port and counter are absent.

Test Plan:
- Defaults, mode=1, run pulsed at T0:
  - ram_re at T0+1+8k for k=0..31 with ram_ra=k; rom_addr matches.
  - ram_we at T0+17+8k with ram_wa=k and ram_wdi=bf_out.
  - done at T0+266; busy falls at T0+266.
- mode=0, in_valid continuous from T0+1:
  - 32 writes at T0+1..T0+32, ram_wa 0..31.
  - done at T0+33.
  - Repeat with in_valid low every other cycle: done at T0+64.
- mode=2 then mode=3: but_sel=1, then 2, for the whole operation; timing identical to the mode=1 case.
- run held high across done: second operation's first ram_re exactly 1 cycle after done; mode toggled mid-op has no effect.
- rst asserted at T0+100 during NTT:
  - from T0+101, all outputs at reset values.
  - no ram_we or done for 20 cycles.
  - a new run operates normally.
- STEPS=1, PIPEDEPTH=3, ADDWID=2: ram_re at T0+1..T0+4, ram_we at T0+4..T0+7, done at T0+8.
